sensor_packet_receiver: RTL and testbench
=========================================

# sensor_packet_receiver

Receiving end of the sensor acquisition AXI-Stream packet format. It sits on the PL side behind the DMA/loopback path, or in the verification harness. It consumes framed packets: header 0xAAAAAAAA, 32-bit timestamp, payload (1024 raw sample words or 3 processed words), and footer 0x55555555 with tlast. It checks framing and re-emits samples, timestamp, processed result and status.

## Interface
- No parameters; all framing constants come from the package.
- master_clock  in  1  sole clock, 40 MHz.
- resetn  in  1  reset, asynchronous, active-low.
- expect_raw_data  in  1  payload mode; sampled when the header is accepted (1 = raw, 0 = processed).
- data_tdata  in  32  AXIS slave data.
- data_tvalid  in  1  AXIS slave valid.
- data_tlast  in  1  AXIS slave last.
- data_tready  out  1  AXIS slave ready; registered.
- sample_data  out  12  raw sample value.
- sample_index  out  10  raw sample index.
- sample_valid  out  1  one-cycle strobe per accepted raw word.
- frame_timestamp  out  32  timestamp of the most recent accepted frame.
- processed_data  out  96  processed words; word0 → [31:0], word1 → [63:32], word2 → [95:64].
- frame_done  out  1  one-cycle pulse when a good frame completes.
- frame_error  out  1  one-cycle pulse when a frame is aborted.
- error_code  out  3  code of the last error; held until the next error.
- frame_count  out  16  count of good frames; wraps.
- error_count  out  16  count of aborted frames; saturates at 0xFFFF.
- dbg_state  out  4  current FSM state.

## Operation
- A beat is accepted when data_tvalid && data_tready.
- States (encoding):
  - IDLE = 0
  - TIME_STAMP = 1
  - RAW_DATA = 2
  - PROC_DATA = 3
  - FOOTER = 4
  - DRAIN = 5
- IDLE:
  - Accepted beat equal to the header → TIME_STAMP; expect_raw_data is latched.
  - Any other beat is discarded silently, with no error (resync).
- TIME_STAMP: the accepted word is captured as the pending timestamp.
  - Goes to RAW_DATA if the latched mode is raw, otherwise PROC_DATA.
  - The internal expected index and word counter clear to 0.
- RAW_DATA: word layout is {reserved[31:22], index[21:12], data[11:0]}.
  - The reserved field must be 0, else error 5 (BAD_RESERVED).
  - The index must equal the expected index, else error 1 (BAD_INDEX).
  - Good word: sample_* is driven and the expected index increments.
  - After index 1023 is accepted → FOOTER.
- PROC_DATA: three words are stored in order into a shadow register, then → FOOTER.
- FOOTER: the accepted beat must equal 0x55555555 with tlast = 1.
  - On success: frame_timestamp and processed_data update from the shadow registers, frame_done pulses, frame_count increments, → IDLE.
  - Processed data updates only in processed mode; a raw frame leaves processed_data unchanged.
  - Wrong value with tlast → error 2 (BAD_FOOTER), → IDLE.
  - Correct value without tlast → error 4 (MISSING_TLAST), → DRAIN.
- tlast on any beat before FOOTER (TIME_STAMP, RAW_DATA, PROC_DATA) → error 3 (EARLY_TLAST), → IDLE.
  - A word that is also malformed still reports code 3.
- Other errors (codes 1 and 5) → DRAIN.
- DRAIN: discards beats until one with tlast is accepted, then → IDLE. No further errors are reported.
- Every error: frame_error pulses, error_code is loaded, error_count increments (saturating).
  - frame_timestamp and processed_data are not updated.
  - Samples already emitted are not retracted.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - data_tready = 0 during reset, goes to 1 on the first clock after resetn deasserts, then stays 1 (no backpressure).
- sample_valid, sample_data and sample_index follow their accepted beat by 1 cycle.
- frame_done and frame_error follow the deciding beat by 1 cycle. Status registers update on the same edge as the pulse.
- Throughput is one beat per clock. A minimal raw frame is 1027 beats; a processed frame is 6 beats.
- Back-to-back frames are allowed: a header may arrive on the beat after the footer.
- tvalid gaps hold state indefinitely.
- Asserting reset mid-frame clears to IDLE immediately. The partial frame is lost and counts as neither done nor error.

## Structure
- Package sensor_packet_pkg holds:
  - HEADER_VALUE and FOOTER_VALUE
  - RAW_LAST_INDEX = 1023 and PROC_WORDS = 3
  - state encoding and error codes (1 BAD_INDEX, 2 BAD_FOOTER, 3 EARLY_TLAST, 4 MISSING_TLAST, 5 BAD_RESERVED)
- Single module with no sub-module; the FSM, checker and shadow registers are all flat.

## Test plan
- Raw frame: header, ts = 0x00001234, words {0, i, i[11:0]} for i = 0..1023, footer+tlast → 1024 sample_valid strobes with index i, frame_timestamp = 0x1234, frame_done once, frame_count = 1.
- Processed frame: header, ts, 0xBBBBBBB, 0xCCCCCCCC, 0xDDDDDDDD, footer+tlast → processed_data = {DDDDDDDD, CCCCCCCC, 0BBBBBBB}, frame_done.
- Index skip: raw frame with index 5 replaced by 6 → frame_error, error_code = 1, samples 0..4 only. Remaining beats drained to tlast; the next good frame completes normally.
- Early tlast: tlast on the timestamp beat → error_code = 3, state back to IDLE. A header on the next beat is accepted.
- Junk before header: 0x12345678 and 0x55555555 preceding a good processed frame → no error, one frame_done, error_count = 0.
- Reset mid-frame: resetn low after 100 raw words → all outputs 0, data_tready = 0. After release, a good frame gives frame_count = 1.

Source files
------------

// File: rtl/sensor_packet_pkg.sv
// Framing constants, FSM state encoding and error codes for the sensor packet receiver.
package sensor_packet_pkg;

  localparam logic [31:0] HEADER_VALUE   = 32'hAAAA_AAAA;
  localparam logic [31:0] FOOTER_VALUE   = 32'h5555_5555;
  localparam logic [9:0]  RAW_LAST_INDEX = 10'd1023;
  localparam int unsigned PROC_WORDS     = 3;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_TIME_STAMP = 4'd1,
    ST_RAW_DATA   = 4'd2,
    ST_PROC_DATA  = 4'd3,
    ST_FOOTER     = 4'd4,
    ST_DRAIN      = 4'd5
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE          = 3'd0,
    ERR_BAD_INDEX     = 3'd1,
    ERR_BAD_FOOTER    = 3'd2,
    ERR_EARLY_TLAST   = 3'd3,
    ERR_MISSING_TLAST = 3'd4,
    ERR_BAD_RESERVED  = 3'd5
  } err_t;

  typedef struct packed {
    logic [9:0]  reserved;
    logic [9:0]  index;
    logic [11:0] data;
  } raw_word_t;

endpackage

// File: rtl/sensor_packet_receiver_if.sv
// AXI-Stream beat bus carrying sensor packets; master drives data, slave drives tready.
interface sensor_packet_receiver_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/sensor_packet_receiver.sv
// Checks sensor packet framing and re-emits samples/status one cycle after the deciding beat.
// tready is held high after reset; no backpressure, one beat per clock.
module sensor_packet_receiver
  import sensor_packet_pkg::*;
(
  input  logic                     master_clock,
  input  logic                     resetn,
  input  logic                     expect_raw_data,
  sensor_packet_receiver_if.slave  data,
  output logic [11:0]              sample_data,
  output logic [9:0]               sample_index,
  output logic                     sample_valid,
  output logic [31:0]              frame_timestamp,
  output logic [95:0]              processed_data,
  output logic                     frame_done,
  output logic                     frame_error,
  output logic [2:0]               error_code,
  output logic [15:0]              frame_count,
  output logic [15:0]              error_count,
  output logic [3:0]               dbg_state
);

  state_t     state, next_state;
  logic       accept;
  raw_word_t  raw_word;
  logic       mode_raw;
  logic [9:0] exp_index;
  logic [1:0] word_cnt;
  logic [31:0] ts_shadow;
  logic [95:0] proc_shadow;
  logic       evt_sample, evt_done, evt_err;
  err_t       err_nxt;

  assign accept    = data.tvalid && data.tready;
  assign raw_word  = raw_word_t'(data.tdata);
  assign dbg_state = state;

  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (accept) begin
      case (state)
        ST_IDLE:       if (data.tdata == HEADER_VALUE) next_state = ST_TIME_STAMP;
        ST_TIME_STAMP: if (data.tlast) next_state = ST_IDLE;
                       else next_state = mode_raw ? ST_RAW_DATA : ST_PROC_DATA;
        ST_RAW_DATA: begin
          if (data.tlast) next_state = ST_IDLE;
          else if (raw_word.reserved != '0 || raw_word.index != exp_index) next_state = ST_DRAIN;
          else if (exp_index == RAW_LAST_INDEX) next_state = ST_FOOTER;
        end
        ST_PROC_DATA: begin
          if (data.tlast) next_state = ST_IDLE;
          else if (word_cnt == 2'(PROC_WORDS - 1)) next_state = ST_FOOTER;
        end
        // Any footer beat ends the frame; without tlast the remainder must be drained.
        ST_FOOTER:     next_state = data.tlast ? ST_IDLE : ST_DRAIN;
        ST_DRAIN:      if (data.tlast) next_state = ST_IDLE;
        default:       next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    evt_sample = 1'b0;
    evt_done   = 1'b0;
    evt_err    = 1'b0;
    err_nxt    = ERR_NONE;
    if (accept) begin
      case (state)
        ST_TIME_STAMP, ST_PROC_DATA: if (data.tlast) begin
          evt_err = 1'b1;
          err_nxt = ERR_EARLY_TLAST;
        end
        ST_RAW_DATA: begin
          if (data.tlast) begin
            evt_err = 1'b1;
            err_nxt = ERR_EARLY_TLAST;
          end else if (raw_word.reserved != '0) begin
            evt_err = 1'b1;
            err_nxt = ERR_BAD_RESERVED;
          end else if (raw_word.index != exp_index) begin
            evt_err = 1'b1;
            err_nxt = ERR_BAD_INDEX;
          end else begin
            evt_sample = 1'b1;
          end
        end
        ST_FOOTER: begin
          if (data.tdata == FOOTER_VALUE && data.tlast) evt_done = 1'b1;
          else begin
            evt_err = 1'b1;
            err_nxt = (data.tdata == FOOTER_VALUE) ? ERR_MISSING_TLAST : ERR_BAD_FOOTER;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      data.tready     <= 1'b0;
      mode_raw        <= 1'b0;
      exp_index       <= '0;
      word_cnt        <= '0;
      ts_shadow       <= '0;
      proc_shadow     <= '0;
      sample_data     <= '0;
      sample_index    <= '0;
      sample_valid    <= 1'b0;
      frame_timestamp <= '0;
      processed_data  <= '0;
      frame_done      <= 1'b0;
      frame_error     <= 1'b0;
      error_code      <= '0;
      frame_count     <= '0;
      error_count     <= '0;
    end else begin
      data.tready  <= 1'b1;
      sample_valid <= evt_sample;
      frame_done   <= evt_done;
      frame_error  <= evt_err;
      if (accept && state == ST_IDLE && data.tdata == HEADER_VALUE) mode_raw <= expect_raw_data;
      if (accept && state == ST_TIME_STAMP) begin
        ts_shadow <= data.tdata;
        exp_index <= '0;
        word_cnt  <= '0;
      end
      if (evt_sample) begin
        sample_data  <= raw_word.data;
        sample_index <= raw_word.index;
        exp_index    <= exp_index + 10'd1;
      end
      // Shift in from the top so word0 ends up in [31:0] after the third word.
      if (accept && state == ST_PROC_DATA) begin
        proc_shadow <= {data.tdata, proc_shadow[95:32]};
        word_cnt    <= word_cnt + 2'd1;
      end
      if (evt_done) begin
        frame_timestamp <= ts_shadow;
        if (!mode_raw) processed_data <= proc_shadow;
        frame_count <= frame_count + 16'd1;
      end
      if (evt_err) begin
        error_code <= err_nxt;
        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sensor_packet_receiver.sv
// Directed bench for sensor_packet_receiver: framing, error paths, back-to-back and reset.
module tb_sensor_packet_receiver;
  import sensor_packet_pkg::*;

  logic        master_clock = 1'b0;
  logic        resetn;
  logic        expect_raw_data;
  logic [11:0] sample_data;
  logic [9:0]  sample_index;
  logic        sample_valid;
  logic [31:0] frame_timestamp;
  logic [95:0] processed_data;
  logic        frame_done;
  logic        frame_error;
  logic [2:0]  error_code;
  logic [15:0] frame_count;
  logic [15:0] error_count;
  logic [3:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_frames = 0;
  int exp_errors = 0;
  logic [31:0] exp_ts = '0;
  logic [95:0] exp_proc = '0;

  always #10 master_clock = ~master_clock;

  sensor_packet_receiver_if bus ();

  sensor_packet_receiver dut (
    .master_clock    (master_clock),
    .resetn          (resetn),
    .expect_raw_data (expect_raw_data),
    .data            (bus),
    .sample_data     (sample_data),
    .sample_index    (sample_index),
    .sample_valid    (sample_valid),
    .frame_timestamp (frame_timestamp),
    .processed_data  (processed_data),
    .frame_done      (frame_done),
    .frame_error     (frame_error),
    .error_code      (error_code),
    .frame_count     (frame_count),
    .error_count     (error_count),
    .dbg_state       (dbg_state)
  );

  // One beat presented for one clock; outputs are sampled 1 time unit after the edge.
  task automatic beat(input logic [31:0] d, input logic l);
    bus.tdata  = d;
    bus.tlast  = l;
    bus.tvalid = 1'b1;
    @(posedge master_clock);
    #1;
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge master_clock);
    #1;
  endtask

  task automatic send_proc(input logic [31:0] ts, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2);
    expect_raw_data = 1'b0;
    beat(HEADER_VALUE, 1'b0);
    beat(ts, 1'b0);
    beat(w0, 1'b0);
    beat(w1, 1'b0);
    beat(w2, 1'b0);
    beat(FOOTER_VALUE, 1'b1);
  endtask

  function automatic logic [31:0] raw_word(input int idx, input int val);
    logic [31:0] w;
    w = {10'd0, 10'(idx), 12'(val)};
    return w;
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    expect_raw_data = 1'b0;
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
    bus.tdata  = '0;
    idle(3);
    n_cmp++; if (bus.tready !== 1'b0) begin n_bad++; $display("FAIL reset_tready: got %b want 0", bus.tready); end
    n_cmp++; if (dbg_state !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    n_cmp++; if ({sample_data, sample_index, sample_valid, frame_timestamp, processed_data, frame_done,
                  frame_error, error_code, frame_count, error_count} !== 188'd0) begin
      n_bad++; $display("FAIL reset_outputs: got nonzero, frame_count %h error_count %h", frame_count, error_count);
    end
    resetn = 1'b1;
    idle(1);
    n_cmp++; if (bus.tready !== 1'b1) begin n_bad++; $display("FAIL tready_after_reset: got %b want 1", bus.tready); end
  endtask

  task automatic test_raw_frame();
    expect_raw_data = 1'b1;
    beat(HEADER_VALUE, 1'b0);
    expect_raw_data = 1'b0;
    n_cmp++; if (dbg_state !== 4'd1) begin n_bad++; $display("FAIL raw_hdr_state: got %0d want 1", dbg_state); end
    beat(32'h0000_1234, 1'b0);
    n_cmp++; if (dbg_state !== 4'd2) begin n_bad++; $display("FAIL raw_ts_state: got %0d want 2", dbg_state); end
    for (int i = 0; i < 1024; i++) begin
      beat(raw_word(i, i), 1'b0);
      n_cmp++;
      if ({sample_valid, sample_index, sample_data} !== {1'b1, 10'(i), 12'(i)}) begin
        n_bad++;
        $display("FAIL raw_sample[%0d]: got v%b idx %0d dat %h want v1 idx %0d dat %h",
                 i, sample_valid, sample_index, sample_data, i, 12'(i));
      end
    end
    n_cmp++; if (dbg_state !== 4'd4) begin n_bad++; $display("FAIL raw_footer_state: got %0d want 4", dbg_state); end
    beat(FOOTER_VALUE, 1'b1);
    exp_frames++;
    exp_ts = 32'h0000_1234;
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL raw_done: got %b want 1", frame_done); end
    n_cmp++; if (frame_timestamp !== exp_ts) begin n_bad++; $display("FAIL raw_ts: got %h want %h", frame_timestamp, exp_ts); end
    n_cmp++; if (frame_count !== 16'(exp_frames)) begin n_bad++; $display("FAIL raw_count: got %0d want %0d", frame_count, exp_frames); end
    n_cmp++; if (processed_data !== exp_proc) begin n_bad++; $display("FAIL raw_proc_kept: got %h want %h", processed_data, exp_proc); end
    n_cmp++; if (dbg_state !== 4'd0) begin n_bad++; $display("FAIL raw_end_state: got %0d want 0", dbg_state); end
    idle(1);
    n_cmp++; if ({frame_done, sample_valid} !== 2'b00) begin n_bad++; $display("FAIL raw_pulses_end: got %b want 00", {frame_done, sample_valid}); end
  endtask

  task automatic test_processed();
    expect_raw_data = 1'b0;
    beat(HEADER_VALUE, 1'b0);
    expect_raw_data = 1'b1;
    beat(32'hCAFE_0001, 1'b0);
    beat(32'h0BBB_BBBB, 1'b0);
    idle(3);
    n_cmp++; if ({dbg_state, sample_valid} !== {4'd3, 1'b0}) begin n_bad++; $display("FAIL proc_gap_state: got %0d/%b want 3/0", dbg_state, sample_valid); end
    beat(32'hCCCC_CCCC, 1'b0);
    beat(32'hDDDD_DDDD, 1'b0);
    n_cmp++; if (dbg_state !== 4'd4) begin n_bad++; $display("FAIL proc_footer_state: got %0d want 4", dbg_state); end
    beat(FOOTER_VALUE, 1'b1);
    exp_frames++;
    exp_ts = 32'hCAFE_0001;
    exp_proc = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'h0BBB_BBBB};
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL proc_done: got %b want 1", frame_done); end
    n_cmp++; if (processed_data !== exp_proc) begin n_bad++; $display("FAIL proc_data: got %h want %h", processed_data, exp_proc); end
    n_cmp++; if (frame_timestamp !== exp_ts) begin n_bad++; $display("FAIL proc_ts: got %h want %h", frame_timestamp, exp_ts); end
    n_cmp++; if (frame_count !== 16'(exp_frames)) begin n_bad++; $display("FAIL proc_count: got %0d want %0d", frame_count, exp_frames); end
  endtask

  task automatic test_junk();
    beat(32'h1234_5678, 1'b0);
    n_cmp++; if ({dbg_state, frame_error} !== {4'd0, 1'b0}) begin n_bad++; $display("FAIL junk1: got %0d/%b want 0/0", dbg_state, frame_error); end
    beat(32'h5555_5555, 1'b0);
    n_cmp++; if ({dbg_state, frame_error} !== {4'd0, 1'b0}) begin n_bad++; $display("FAIL junk2: got %0d/%b want 0/0", dbg_state, frame_error); end
    send_proc(32'h0000_0042, 32'h1, 32'h2, 32'h3);
    exp_frames++;
    exp_ts = 32'h0000_0042;
    exp_proc = {32'h3, 32'h2, 32'h1};
    n_cmp++; if ({frame_done, frame_error} !== 2'b10) begin n_bad++; $display("FAIL junk_done: got %b want 10", {frame_done, frame_error}); end
    n_cmp++; if (error_count !== 16'd0) begin n_bad++; $display("FAIL junk_errcnt: got %0d want 0", error_count); end
    n_cmp++; if (processed_data !== exp_proc) begin n_bad++; $display("FAIL junk_proc: got %h want %h", processed_data, exp_proc); end
  endtask

  task automatic test_index_skip();
    int extra;
    extra = 0;
    expect_raw_data = 1'b1;
    beat(HEADER_VALUE, 1'b0);
    beat(32'h0000_0077, 1'b0);
    for (int i = 0; i < 5; i++) begin
      beat(raw_word(i, i + 100), 1'b0);
      n_cmp++;
      if ({sample_valid, sample_index, sample_data} !== {1'b1, 10'(i), 12'(i + 100)}) begin
        n_bad++; $display("FAIL skip_sample[%0d]: got v%b idx %0d dat %h", i, sample_valid, sample_index, sample_data);
      end
    end
    beat(raw_word(6, 106), 1'b0);
    exp_errors++;
    n_cmp++; if ({frame_error, error_code} !== {1'b1, 3'd1}) begin n_bad++; $display("FAIL skip_err: got %b/%0d want 1/1", frame_error, error_code); end
    n_cmp++; if ({sample_valid, sample_index} !== {1'b0, 10'd4}) begin n_bad++; $display("FAIL skip_nosample: got v%b idx %0d want v0 idx 4", sample_valid, sample_index); end
    n_cmp++; if (dbg_state !== 4'd5) begin n_bad++; $display("FAIL skip_drain_state: got %0d want 5", dbg_state); end
    n_cmp++; if (error_count !== 16'(exp_errors)) begin n_bad++; $display("FAIL skip_errcnt: got %0d want %0d", error_count, exp_errors); end
    for (int i = 7; i < 1024; i++) begin
      beat(raw_word(i, i), 1'b0);
      extra += int'(sample_valid) + int'(frame_error) + int'(frame_done);
    end
    beat(FOOTER_VALUE, 1'b1);
    extra += int'(sample_valid) + int'(frame_error) + int'(frame_done);
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL skip_drain_pulses: got %0d want 0", extra); end
    n_cmp++; if (dbg_state !== 4'd0) begin n_bad++; $display("FAIL skip_idle: got %0d want 0", dbg_state); end
    n_cmp++; if (frame_timestamp !== exp_ts) begin n_bad++; $display("FAIL skip_ts_kept: got %h want %h", frame_timestamp, exp_ts); end
    send_proc(32'h0000_0099, 32'hA, 32'hB, 32'hC);
    exp_frames++;
    exp_ts = 32'h0000_0099;
    exp_proc = {32'hC, 32'hB, 32'hA};
    n_cmp++; if ({frame_done, frame_count} !== {1'b1, 16'(exp_frames)}) begin n_bad++; $display("FAIL skip_recover: got %b/%0d want 1/%0d", frame_done, frame_count, exp_frames); end
  endtask

  task automatic test_early_tlast();
    expect_raw_data = 1'b0;
    beat(HEADER_VALUE, 1'b0);
    beat(32'hDEAD_0001, 1'b1);
    exp_errors++;
    n_cmp++; if ({frame_error, error_code, dbg_state} !== {1'b1, 3'd3, 4'd0}) begin n_bad++; $display("FAIL early_err: got %b/%0d/%0d want 1/3/0", frame_error, error_code, dbg_state); end
    n_cmp++; if (error_count !== 16'(exp_errors)) begin n_bad++; $display("FAIL early_errcnt: got %0d want %0d", error_count, exp_errors); end
    n_cmp++; if (frame_timestamp !== exp_ts) begin n_bad++; $display("FAIL early_ts_kept: got %h want %h", frame_timestamp, exp_ts); end
    beat(HEADER_VALUE, 1'b0);
    n_cmp++; if ({dbg_state, frame_error} !== {4'd1, 1'b0}) begin n_bad++; $display("FAIL early_rehdr: got %0d/%b want 1/0", dbg_state, frame_error); end
    beat(32'h0000_0100, 1'b0);
    beat(32'h11, 1'b0);
    beat(32'h22, 1'b0);
    beat(32'h33, 1'b0);
    beat(FOOTER_VALUE, 1'b1);
    exp_frames++;
    exp_ts = 32'h0000_0100;
    exp_proc = {32'h33, 32'h22, 32'h11};
    n_cmp++; if ({frame_done, frame_count} !== {1'b1, 16'(exp_frames)}) begin n_bad++; $display("FAIL early_recover: got %b/%0d want 1/%0d", frame_done, frame_count, exp_frames); end
  endtask

  task automatic test_footer_errors();
    expect_raw_data = 1'b0;
    beat(HEADER_VALUE, 1'b0);
    beat(32'h0000_0200, 1'b0);
    beat(32'h1, 1'b0);
    beat(32'h2, 1'b0);
    beat(32'h3, 1'b0);
    beat(32'h1212_1212, 1'b1);
    exp_errors++;
    n_cmp++; if ({frame_error, error_code, dbg_state} !== {1'b1, 3'd2, 4'd0}) begin n_bad++; $display("FAIL badfooter: got %b/%0d/%0d want 1/2/0", frame_error, error_code, dbg_state); end
    n_cmp++; if (processed_data !== exp_proc) begin n_bad++; $display("FAIL badfooter_proc_kept: got %h want %h", processed_data, exp_proc); end
    beat(HEADER_VALUE, 1'b0);
    beat(32'h0000_0300, 1'b0);
    beat(32'h4, 1'b0);
    beat(32'h5, 1'b0);
    beat(32'h6, 1'b0);
    beat(FOOTER_VALUE, 1'b0);
    exp_errors++;
    n_cmp++; if ({frame_error, error_code, dbg_state} !== {1'b1, 3'd4, 4'd5}) begin n_bad++; $display("FAIL notlast: got %b/%0d/%0d want 1/4/5", frame_error, error_code, dbg_state); end
    beat(32'h0, 1'b0);
    beat(32'h0, 1'b1);
    n_cmp++; if ({frame_error, dbg_state, error_count} !== {1'b0, 4'd0, 16'(exp_errors)}) begin n_bad++; $display("FAIL notlast_drain: got %b/%0d/%0d want 0/0/%0d", frame_error, dbg_state, error_count, exp_errors); end
    n_cmp++; if (frame_timestamp !== exp_ts) begin n_bad++; $display("FAIL notlast_ts_kept: got %h want %h", frame_timestamp, exp_ts); end
  endtask

  task automatic test_reserved();
    logic [31:0] w;
    w = {10'h001, 10'd0, 12'd0};
    expect_raw_data = 1'b1;
    beat(HEADER_VALUE, 1'b0);
    beat(32'h0000_0400, 1'b0);
    beat(w, 1'b0);
    exp_errors++;
    n_cmp++; if ({frame_error, error_code, dbg_state, sample_valid} !== {1'b1, 3'd5, 4'd5, 1'b0}) begin n_bad++; $display("FAIL reserved: got %b/%0d/%0d/%b want 1/5/5/0", frame_error, error_code, dbg_state, sample_valid); end
    beat(32'h0, 1'b1);
    n_cmp++; if ({dbg_state, error_count} !== {4'd0, 16'(exp_errors)}) begin n_bad++; $display("FAIL reserved_end: got %0d/%0d want 0/%0d", dbg_state, error_count, exp_errors); end
  endtask

  task automatic test_back_to_back();
    send_proc(32'h0000_0501, 32'h51, 32'h52, 32'h53);
    exp_frames++;
    n_cmp++; if ({frame_done, frame_count} !== {1'b1, 16'(exp_frames)}) begin n_bad++; $display("FAIL b2b_first: got %b/%0d want 1/%0d", frame_done, frame_count, exp_frames); end
    send_proc(32'h0000_0502, 32'h61, 32'h62, 32'h63);
    exp_frames++;
    exp_ts = 32'h0000_0502;
    exp_proc = {32'h63, 32'h62, 32'h61};
    n_cmp++; if ({frame_done, frame_count} !== {1'b1, 16'(exp_frames)}) begin n_bad++; $display("FAIL b2b_second: got %b/%0d want 1/%0d", frame_done, frame_count, exp_frames); end
    n_cmp++; if ({frame_timestamp, processed_data} !== {exp_ts, exp_proc}) begin n_bad++; $display("FAIL b2b_data: got %h %h want %h %h", frame_timestamp, processed_data, exp_ts, exp_proc); end
  endtask

  task automatic test_reset_mid();
    expect_raw_data = 1'b1;
    beat(HEADER_VALUE, 1'b0);
    beat(32'h0000_0600, 1'b0);
    for (int i = 0; i < 100; i++) beat(raw_word(i, i), 1'b0);
    #3;
    resetn = 1'b0;
    #1;
    n_cmp++; if ({bus.tready, dbg_state} !== {1'b0, 4'd0}) begin n_bad++; $display("FAIL midreset_state: got %b/%0d want 0/0", bus.tready, dbg_state); end
    n_cmp++; if ({sample_data, sample_index, sample_valid, frame_timestamp, processed_data, frame_done,
                  frame_error, error_code, frame_count, error_count} !== 188'd0) begin
      n_bad++; $display("FAIL midreset_outputs: got nonzero, frame_count %h idx %h", frame_count, sample_index);
    end
    idle(2);
    resetn = 1'b1;
    idle(1);
    exp_frames = 0;
    exp_errors = 0;
    send_proc(32'h0000_0700, 32'h71, 32'h72, 32'h73);
    exp_frames++;
    n_cmp++; if ({frame_done, frame_count, error_count} !== {1'b1, 16'(exp_frames), 16'(exp_errors)}) begin n_bad++; $display("FAIL midreset_recover: got %b/%0d/%0d want 1/%0d/%0d", frame_done, frame_count, error_count, exp_frames, exp_errors); end
  endtask

  initial begin
    test_reset();
    test_raw_frame();
    test_processed();
    test_junk();
    test_index_skip();
    test_early_tlast();
    test_footer_errors();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
